floor_scheduler: RTL

FLOOR_SCHEDULER -- requirements
Module: floor_scheduler

---
 rtl/floor_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/floor_scheduler.sv
// Three-floor car scheduler: latches hall/cabin calls, moves the car and opens the door at each served floor.
// Optional build macro FLOOR_SCHED_AUTH_GATE_EN: cabin calls count only while auth is high.
module floor_scheduler #(
  parameter int FLOOR_CYCLES = 4,
  parameter int DOOR_CYCLES  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] interior_movement,
  input  logic [2:0] exterior_movement,
  input  logic       auth,
  output logic [1:0] engine,
  output logic [2:0] doors,
  output logic [1:0] cur_floor,
  output logic [2:0] pending
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  localparam int TW = $clog2(FLOOR_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(FLOOR_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

  logic [1:0]    state, state_n;
  logic          dir, dir_n;  // 1 = up
  logic [1:0]    floor_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [2:0]    pending_n;
  logic [2:0]    int_qual;
  logic [2:0]    req;
  logic [2:0]    clear;

`ifdef FLOOR_SCHED_AUTH_GATE_EN
  assign int_qual = interior_movement & {3{auth}};
`else
  logic unused_auth;
  assign unused_auth = auth;
  assign int_qual    = interior_movement;
`endif

  assign req = exterior_movement | int_qual;

  // True when some outstanding call lies strictly beyond floor f in the given direction.
  function automatic logic req_ahead(input logic [2:0] pend, input logic [1:0] f, input logic up);
    logic r;
    r = 1'b0;
    case (f)
      2'd0:    r = up ? |pend[2:1] : 1'b0;
      2'd1:    r = up ? pend[2] : pend[0];
      2'd2:    r = up ? 1'b0 : |pend[1:0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_n = state;
    dir_n   = dir;
    floor_n = cur_floor;
    tcnt_n  = tcnt;
    dcnt_n  = dcnt;
    case (state)
      S_IDLE: begin
        if (pending[cur_floor]) begin
          state_n = S_DOOR;
          dcnt_n  = '0;
        end else if (pending != 3'b000) begin
          state_n = S_MOVE;
          tcnt_n  = '0;
          dir_n   = req_ahead(pending, cur_floor, dir) ? dir : ~dir;
        end
      end
      S_MOVE: begin
        if ((dir && cur_floor == 2'd2) || (!dir && cur_floor == 2'd0)) begin
          // Never drive past the end floors; park instead.
          state_n = S_IDLE;
          tcnt_n  = '0;
        end else if (tcnt == T_LAST) begin
          tcnt_n  = '0;
          floor_n = dir ? cur_floor + 2'd1 : cur_floor - 2'd1;
          if (pending[floor_n]) begin
            state_n = S_DOOR;
            dcnt_n  = '0;
          end else if (!req_ahead(pending, floor_n, dir)) begin
            state_n = S_IDLE;
          end
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      S_DOOR: begin
        if (req[cur_floor]) begin
          dcnt_n = '0;
        end else if (dcnt == D_LAST) begin
          state_n = S_IDLE;
          dcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    // The floor being served is cleared; its clear beats any new call for it, other floors' sets win.
    clear     = (state_n == S_DOOR) ? (3'b001 << floor_n) : 3'b000;
    pending_n = (pending | req) & ~clear;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    // NOTE: synchronous reset also drops any call presented in the reset cycle.
    if (RST) begin
      state     <= S_IDLE;
      dir       <= 1'b1;
      cur_floor <= 2'd0;
      tcnt      <= '0;
      dcnt      <= '0;
      pending   <= 3'b000;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      cur_floor <= floor_n;
      tcnt      <= tcnt_n;
      dcnt      <= dcnt_n;
      pending   <= pending_n;
    end
  end

  assign engine = (state == S_MOVE) ? (dir ? 2'b01 : 2'b10) : 2'b00;
  assign doors  = (state == S_DOOR) ? (3'b001 << cur_floor) : 3'b000;

endmodule
